// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: shared widths, response-owner enum and counter sizing for the instruction memory arbiter
package imem_arbiter_pkg;
  localparam int BW_DEF = 32;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_t;
  function automatic int cnt_width(input int max_val);
    return ($clog2(max_val + 1) > 3) ? $clog2(max_val + 1) : 3;
  endfunction
endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, loader and RAM command/response signals shared by the arbiter and its clients
interface imem_arbiter_if #(parameter int BW = 32, parameter int DW = 8);
  logic          f_req;
  logic [DW-1:0] f_addr;
  logic          f_flush;
  logic          f_gnt;
  logic          f_rvalid;
  logic [BW-1:0] f_rdata;
  logic          l_req;
  logic          l_we;
  logic [DW-1:0] l_addr;
  logic [BW-1:0] l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [BW-1:0] l_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata;
  logic [BW-1:0] mem_rdata;
  modport master (
    output f_req, f_addr, f_flush, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  f_req, f_addr, f_flush, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: loader-priority arbitration of one sync RAM port with fetch anti-starvation and flush-aware response routing
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int BW         = BW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input logic         clk,
  input logic         rst,
  imem_arbiter_if.slave bus
);
  localparam int CW = cnt_width(STARVE_MAX);
  logic [CW-1:0] starve_cnt;
  owner_t        owner;
  logic          f_win, l_win, f_own, l_own;
  always_comb begin
    f_win = !rst && bus.f_req && (!bus.l_req || starve_cnt == CW'(STARVE_MAX));
    l_win = !rst && bus.l_req && !f_win;
    f_own = owner == OWN_FETCH && !bus.f_flush;
    l_own = owner == OWN_LOAD;
  end
  assign bus.f_gnt     = f_win;
  assign bus.l_gnt     = l_win;
  assign bus.mem_en    = f_win || l_win;
  assign bus.mem_we    = l_win && bus.l_we;
  assign bus.mem_addr  = f_win ? bus.f_addr : l_win ? bus.l_addr : DW'(0);
  assign bus.mem_wdata = l_win ? bus.l_wdata : BW'(0);
  assign bus.f_rvalid  = f_own;
  assign bus.f_rdata   = f_own ? bus.mem_rdata : BW'(0);
  assign bus.l_rvalid  = l_own;
  assign bus.l_rdata   = l_own ? bus.mem_rdata : BW'(0);
  // a fetch granted under flush is already stale, so it never claims the response slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      owner      <= OWN_NONE;
    end else begin
      starve_cnt <= (!bus.f_req || f_win) ? '0 :
                    (starve_cnt == CW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
      owner      <= (f_win && !bus.f_flush) ? OWN_FETCH :
                    (l_win && !bus.l_we) ? OWN_LOAD : OWN_NONE;
    end
  end
endmodule
